exe_muldiv_seq: RTL and testbench
=================================

// Module: exe_muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the EXE-stage ALU. When EXE holds an M-ext
//  instruction it captures the forwarded operands and runs a 32-step shift-add / restoring-divide
//  loop. It holds md_stall high to freeze IF/ID/EXE until the result is ready.
//  The result is muxed onto the EXE result path for exactly one cycle (md_result_valid).
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   iteration counter width (must hold XLEN)
// PORTS
//  clk              in   1     system clock, rising edge
//  rst              in   1     asynchronous, active-low reset
//  md_start         in   1     EXE holds MUL/DIV-class instr (held high while md_stall=1)
//  md_function_3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  md_rs1           in   XLEN  forwarded rs1 (post ForwardA mux), sampled on accept only
//  md_rs2           in   XLEN  forwarded rs2 (post ForwardB mux), sampled on accept only
//  flush            in   1     branch/jump flush of EXE; aborts any op
//  md_stall         out  1     freeze IF/ID/EXE pipeline registers
//  md_busy          out  1     state is MUL or DIV
//  md_result_valid  out  1     md_result valid this cycle (one-cycle pulse)
//  md_result        out  XLEN  selected result word
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, all internal regs 0, md_result 0, md_result_valid 0, md_busy 0.
//  - States: IDLE, MUL, DIV, DONE.
//  - IDLE: md_start=1 & flush=0 accepts the op. Capture f3, |rs1|, |rs2| and result-sign flags.
//    Next state is MUL for f3[2]=0. Next state is DONE for a DIV special case. Otherwise DIV.
//  - MUL/DIV: one iteration per cycle, counter 0..31. After iteration 31, next state DONE.
//  - DONE: md_result_valid=1 and md_result is driven. Next state is always IDLE.
//    Same-cycle md_start is ignored and the op is re-sampled in IDLE.
//  - md_stall = (IDLE & md_start & ~flush) | MUL | DIV. md_stall is 0 in DONE so the pipeline
//    advances with the result.
//  - Latency, normal op accepted in cycle N: stall high cycles N..N+32, valid in cycle N+33.
//  - Latency, special-case DIV accepted in cycle N: stall in cycle N only, valid in cycle N+1.
//  - Signed handling: operand treated signed per op (MULH both, MULHSU rs1 only, DIV/REM both).
//    Magnitudes are processed unsigned. Product is negated if the operand signs differ.
//    Quotient is negated if the signs differ; remainder takes the sign of the dividend.
//  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32] (64-bit internal acc).
//  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = rs1. No trap.
//  - Overflow, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
//  - flush=1 in any state: next state IDLE, no md_result_valid, internal regs may be left stale.
//    Flush wins over a simultaneous md_start.
//  - md_result holds its last value outside DONE. Consumers gate on md_result_valid only.
//  - Reset asserted mid-op returns immediately to the reset state. There is no result and no
//    stall after release.
// TESTING
//  1. MUL rs1=7, rs2=0xFFFFFFFD, start in cycle N -> stall N..N+32, valid in N+33, result 0xFFFFFFEB.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000.
//     MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF.
//  3. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
//     DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. Each valid one cycle after accept, stall one cycle only.
//  5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Single-cycle path.
//  6. Start a DIV, flush in cycle N+10 -> IDLE in N+11, no valid pulse.
//     Then rst low at mid-op of a new MUL -> all outputs 0 asynchronously, idle after release.

Source files
------------

// File: rtl/exe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EXE stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a pipeline stall handshake.
module exe_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_start,
    input  logic [2:0]      md_function_3,
    input  logic [XLEN-1:0] md_rs1,
    input  logic [XLEN-1:0] md_rs2,
    input  logic            flush,
    output logic            md_stall,
    output logic            md_busy,
    output logic            md_result_valid,
    output logic [XLEN-1:0] md_result
);

    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3;
    logic [XLEN-1:0]  opnd;
    logic [AW-1:0]    acc;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             s1;
    logic             s2;
    logic [XLEN-1:0]  abs1;
    logic [XLEN-1:0]  abs2;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    mul_sum;
    logic [AW-1:0]    mul_next;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [AW-1:0]    div_next;
    logic [AW-1:0]    prod_fin;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  mul_res;
    logic [XLEN-1:0]  div_res;
    logic             last;

    // Operand decode at accept plus one iteration step of the datapath.
    always_comb begin
        accept = (state == S_IDLE) && md_start && !flush;

        // rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM
        s1 = md_rs1[XLEN-1] && (md_function_3[2] ? !md_function_3[0]
                                                 : (md_function_3[1:0] == 2'b01 ||
                                                    md_function_3[1:0] == 2'b10));
        s2 = md_rs2[XLEN-1] && (md_function_3[2] ? !md_function_3[0]
                                                 : (md_function_3[1:0] == 2'b01));
        abs1 = s1 ? (XLEN'(0) - md_rs1) : md_rs1;
        abs2 = s2 ? (XLEN'(0) - md_rs2) : md_rs2;

        div_zero = (md_rs2 == '0);
        div_ovf  = !md_function_3[0] && (md_rs1 == MIN_NEG) && (md_rs2 == '1);
        if (div_zero) begin
            special_res = md_function_3[1] ? md_rs1 : '1;
        end else begin
            special_res = md_function_3[1] ? '0 : MIN_NEG;
        end

        // Multiply: acc = {partial product high, remaining multiplier bits}
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // Restoring divide: acc = {remainder, dividend shifting into quotient}
        div_shift = acc[AW-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_next  = {(div_ge ? XLEN'(div_shift - {1'b0, opnd}) : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};

        prod_fin = neg_q ? (AW'(0) - mul_next) : mul_next;
        mul_res  = (f3[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[AW-1:XLEN];

        quo = div_next[XLEN-1:0];
        rem = div_next[AW-1:XLEN];
        if (f3[1]) begin
            div_res = neg_r ? (XLEN'(0) - rem) : rem;
        end else begin
            div_res = neg_q ? (XLEN'(0) - quo) : quo;
        end

        last = (cnt == CNT_W'(XLEN - 1));
    end

    // Held low in reset so the pipeline never sees a stall from a stale start.
    assign md_stall = rst && (accept || state == S_MUL || state == S_DIV);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            f3              <= '0;
            opnd            <= '0;
            acc             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            md_busy         <= 1'b0;
            md_result_valid <= 1'b0;
            md_result       <= '0;
        end else if (flush) begin
            state           <= S_IDLE;
            cnt             <= '0;
            md_busy         <= 1'b0;
            md_result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    md_result_valid <= 1'b0;
                    if (accept) begin
                        f3    <= md_function_3;
                        cnt   <= '0;
                        neg_q <= s1 ^ s2;
                        neg_r <= s1;
                        if (!md_function_3[2]) begin
                            state   <= S_MUL;
                            opnd    <= abs1;
                            acc     <= {{XLEN{1'b0}}, abs2};
                            md_busy <= 1'b1;
                        end else if (div_zero || div_ovf) begin
                            state           <= S_DONE;
                            md_result       <= special_res;
                            md_result_valid <= 1'b1;
                        end else begin
                            state   <= S_DIV;
                            opnd    <= abs2;
                            acc     <= {{XLEN{1'b0}}, abs1};
                            md_busy <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state           <= S_DONE;
                        md_result       <= mul_res;
                        md_result_valid <= 1'b1;
                        md_busy         <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state           <= S_DONE;
                        md_result       <= div_res;
                        md_result_valid <= 1'b1;
                        md_busy         <= 1'b0;
                    end
                end
                S_DONE: begin
                    state           <= S_IDLE;
                    md_result_valid <= 1'b0;
                end
                default: begin
                    state           <= S_IDLE;
                    md_busy         <= 1'b0;
                    md_result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed bench for exe_muldiv_seq: vector table for results and latency,
// plus hand sequences for flush and mid-operation reset.
module tb_exe_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_function_3;
    logic [31:0] md_rs1;
    logic [31:0] md_rs2;
    logic        flush;
    logic        md_stall;
    logic        md_busy;
    logic        md_result_valid;
    logic [31:0] md_result;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    exe_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .md_start        (md_start),
        .md_function_3   (md_function_3),
        .md_rs1          (md_rs1),
        .md_rs2          (md_rs2),
        .flush           (flush),
        .md_stall        (md_stall),
        .md_busy         (md_busy),
        .md_result_valid (md_result_valid),
        .md_result       (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vt.push_back(v);
    endfunction

    // Launch one op; measure cycles to valid and the stall window, check result and hold.
    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        int stalls;
        @(negedge clk);
        md_function_3 = v.f3;
        md_rs1        = v.a;
        md_rs2        = v.b;
        md_start      = 1'b1;
        flush         = 1'b0;
        #1;
        lat    = 0;
        stalls = 0;
        while (!md_result_valid && lat < 40) begin
            if (md_stall) stalls++;
            @(negedge clk);
            lat++;
        end
        md_start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(v.lat));
        check({tag, "_result"}, md_result, v.exp);
        check({tag, "_stall_in_done"}, {31'b0, md_stall}, 32'd0);
        @(negedge clk);
        check({tag, "_valid_pulse"}, {31'b0, md_result_valid}, 32'd0);
        check({tag, "_result_hold"}, md_result, v.exp);
    endtask

    initial begin
        int pulses;
        vec_t v;
        rst = 1'b0;
        md_start = 1'b0;
        md_function_3 = 3'b000;
        md_rs1 = '0;
        md_rs2 = '0;
        flush = 1'b0;

        // MUL / MULH / MULHSU / MULHU
        add(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        add(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        add(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        // DIV / REM / DIVU / REMU
        add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        add(3'b101, 32'd100,       32'd7,         32'd14,        33);
        add(3'b111, 32'd100,       32'd7,         32'd2,         33);
        add(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 33);
        add(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        add(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33);
        // divide-by-zero and overflow take the single-cycle path
        add(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        add(3'b110, 32'd5,         32'd0,         32'd5,         1);
        add(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
        add(3'b111, 32'd7,         32'd0,         32'd7,         1);
        add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_stall",  {31'b0, md_stall}, 32'd0);
        check("reset_busy",   {31'b0, md_busy}, 32'd0);
        check("reset_valid",  {31'b0, md_result_valid}, 32'd0);
        check("reset_result", md_result, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec($sformatf("v%0d", i), vt[i]);
        end

        // Flush ten cycles into a DIV: back to idle, no result pulse.
        @(negedge clk);
        md_function_3 = 3'b101;
        md_rs1 = 32'd100;
        md_rs2 = 32'd7;
        md_start = 1'b1;
        repeat (10) @(negedge clk);
        check("flush_busy_before", {31'b0, md_busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        md_start = 1'b0;
        #1;
        check("flush_busy_after",  {31'b0, md_busy}, 32'd0);
        check("flush_stall_after", {31'b0, md_stall}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (md_result_valid) pulses++;
            @(negedge clk);
        end
        check("flush_no_valid", 32'(pulses), 32'd0);

        // Flush wins over a simultaneous start in idle.
        md_function_3 = 3'b000;
        md_rs1 = 32'd3;
        md_rs2 = 32'd4;
        md_start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_start_stall", {31'b0, md_stall}, 32'd0);
        @(negedge clk);
        md_start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'b0, md_busy}, 32'd0);

        // Reset in the middle of a MUL clears everything asynchronously.
        md_function_3 = 3'b000;
        md_rs1 = 32'd9;
        md_rs2 = 32'd9;
        md_start = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_busy", {31'b0, md_busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_stall",  {31'b0, md_stall}, 32'd0);
        check("async_rst_busy",   {31'b0, md_busy}, 32'd0);
        check("async_rst_valid",  {31'b0, md_result_valid}, 32'd0);
        check("async_rst_result", md_result, 32'd0);
        @(negedge clk);
        md_start = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (md_result_valid || md_stall || md_busy) pulses++;
        end
        check("post_rst_idle", 32'(pulses), 32'd0);

        v.f3 = 3'b000; v.a = 32'd9; v.b = 32'd9; v.exp = 32'd81; v.lat = 33;
        run_vec("post_rst_mul", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
